bp_update_arbiter: RTL and testbench

BP_UPDATE_ARBITER -- requirements
Module: bp_update_arbiter

---
 rtl/bp_update_arbiter_pkg.sv | 16 +
 rtl/bp_update_arbiter_if.sv | 40 ++++
 rtl/bp_update_fifo.sv | 51 +++++
 rtl/bp_update_arbiter.sv | 116 +++++++++++
 tb/tb_bp_update_arbiter.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/bp_update_arbiter_pkg.sv
// Shared types and constants for the branch-predictor update arbiter.
package bp_pkg;

    localparam int PC_W     = 14;
    localparam int BP_IDX_W = 12;
    localparam int BP_DEPTH = 4;

    // Value written into every table entry during the init sweep (weakly not-taken).
    localparam logic [1:0] BP_WEAK_NT = 2'b01;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } bp_state_e;

endpackage

// File: rtl/bp_update_arbiter_if.sv
// Bundle of resolved-branch inputs and predictor-table write outputs.
interface bp_update_arbiter_if #(
    parameter int IDX_W = 12
);
    import bp_pkg::*;

    logic              br0_valid;
    logic [PC_W-1:0]   br0_pc;
    logic              br0_taken;
    logic              br1_valid;
    logic [PC_W-1:0]   br1_pc;
    logic              br1_taken;
    logic              br_ready;

    logic              tbl_we;
    logic [IDX_W-1:0]  tbl_idx;
    logic              tbl_init;
    logic              tbl_taken;
    logic              init_done;
    logic              err_drop;

    // Branch-resolution side: presents updates, observes table writes.
    modport master (
        output br0_valid, br0_pc, br0_taken,
        output br1_valid, br1_pc, br1_taken,
        input  br_ready,
        input  tbl_we, tbl_idx, tbl_init, tbl_taken,
        input  init_done, err_drop
    );

    // Arbiter side.
    modport slave (
        input  br0_valid, br0_pc, br0_taken,
        input  br1_valid, br1_pc, br1_taken,
        output br_ready,
        output tbl_we, tbl_idx, tbl_init, tbl_taken,
        output init_done, err_drop
    );

endinterface

// File: rtl/bp_update_fifo.sv
// Two-write / one-read update FIFO. Write port 0 lands ahead of write port 1
// when both fire in the same cycle. Storage is not reset; only pointers and
// count are, so the head is meaningful only while count is non-zero.
module bp_update_fifo #(
    parameter int W     = 13,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr0_en,
    input  logic [W-1:0]               wr0_data,
    input  logic                       wr1_en,
    input  logic [W-1:0]               wr1_data,
    input  logic                       rd_en,
    output logic [W-1:0]               head,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wptr;
    logic [PTR_W-1:0] wptr1;
    logic [PTR_W-1:0] rptr;
    logic             rd_ok;

    // Lane 1 goes into the slot after lane 0 only if lane 0 actually wrote.
    assign wptr1 = wptr + PTR_W'(wr0_en);
    assign rd_ok = rd_en && (count != '0);
    assign head  = mem[rptr];

    // Entry storage; pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (wr0_en) mem[wptr]  <= wr0_data;
        if (wr1_en) mem[wptr1] <= wr1_data;
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            wptr  <= wptr + PTR_W'(wr0_en) + PTR_W'(wr1_en);
            rptr  <= rptr + PTR_W'(rd_ok);
            count <= count + CNT_W'(wr0_en) + CNT_W'(wr1_en) - CNT_W'(rd_ok);
        end
    end

endmodule

// File: rtl/bp_update_arbiter.sv
// Branch-predictor update arbiter: sweeps the table to weakly-not-taken after
// reset, then funnels up to two resolved branches per cycle through a small
// FIFO into a single table write port. Lost updates raise a sticky error.
module bp_update_arbiter
    import bp_pkg::*;
#(
    parameter int IDX_W = BP_IDX_W,
    parameter int DEPTH = BP_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    bp_update_arbiter_if.slave bus
);
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int ENT_W = IDX_W + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = '1;

    bp_state_e         state;
    bp_state_e         state_nxt;
    logic [IDX_W-1:0]  sweep_idx;
    logic              err_q;
    logic [CNT_W-1:0]  count;
    logic [ENT_W-1:0]  head;
    logic [IDX_W-1:0]  idx0;
    logic [IDX_W-1:0]  idx1;
    logic              br_ready;
    logic              enq0;
    logic              enq1;
    logic              deq;
    logic              drop;
    logic              tbl_we;
    logic [IDX_W-1:0]  tbl_idx;
    logic              tbl_init;
    logic              tbl_taken;
    logic              unused_pc_bits;

    // Word-aligned PC bits select the entry; upper bits simply alias.
    assign idx0 = bus.br0_pc[IDX_W+1:2];
    assign idx1 = bus.br1_pc[IDX_W+1:2];
    assign unused_pc_bits = ^{bus.br0_pc, bus.br1_pc};

    assign enq0 = bus.br0_valid && br_ready;
    assign enq1 = bus.br1_valid && br_ready;
    assign drop = (bus.br0_valid || bus.br1_valid) && !br_ready;
    assign deq  = (state == RUN) && (count != '0);

    bp_update_fifo #(
        .W     (ENT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .wr0_en   (enq0),
        .wr0_data ({idx0, bus.br0_taken}),
        .wr1_en   (enq1),
        .wr1_data ({idx1, bus.br1_taken}),
        .rd_en    (deq),
        .head     (head),
        .count    (count)
    );

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= INIT;
        else      state <= state_nxt;
    end

    // Leave INIT once the last table index has been written.
    always_comb begin
        state_nxt = state;
        if (state == INIT && sweep_idx == LAST_IDX) state_nxt = RUN;
    end

    // Init sweep index, one entry per cycle while in INIT.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                sweep_idx <= '0;
        else if (state == INIT)  sweep_idx <= sweep_idx + IDX_W'(1);
    end

    // Sticky record of any update offered while the arbiter could not take it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)      err_q <= 1'b0;
        else if (drop) err_q <= 1'b1;
    end

    // Table port and ready: sweep in INIT, FIFO head in RUN, quiet in reset.
    always_comb begin
        br_ready  = 1'b0;
        tbl_we    = 1'b0;
        tbl_init  = 1'b0;
        tbl_idx   = '0;
        tbl_taken = 1'b0;
        if (rst) begin
            if (state == INIT) begin
                tbl_we   = 1'b1;
                tbl_init = 1'b1;
                tbl_idx  = sweep_idx;
            end else begin
                // Need room for two entries regardless of this cycle's dequeue.
                br_ready  = (count <= CNT_W'(DEPTH - 2));
                tbl_we    = (count != '0);
                tbl_idx   = head[ENT_W-1:1];
                tbl_taken = head[0];
            end
        end
    end

    assign bus.br_ready  = br_ready;
    assign bus.tbl_we    = tbl_we;
    assign bus.tbl_idx   = tbl_idx;
    assign bus.tbl_init  = tbl_init;
    assign bus.tbl_taken = tbl_taken;
    assign bus.init_done = (state == RUN);
    assign bus.err_drop  = err_q;

endmodule

// File: tb/tb_bp_update_arbiter.sv
// Directed bench for bp_update_arbiter with IDX_W=4, DEPTH=4.
module tb_bp_update_arbiter;
    import bp_pkg::*;

    localparam int IDX_W = 4;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    bp_update_arbiter_if #(.IDX_W(IDX_W)) bus ();

    bp_update_arbiter #(
        .IDX_W (IDX_W),
        .DEPTH (DEPTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic        b0v;
        logic [13:0] b0pc;
        logic        b0t;
        logic        b1v;
        logic [13:0] b1pc;
        logic        b1t;
        logic        rdy;
        logic        we;
        logic [3:0]  idx;
        logic        tk;
        logic        err;
    } vec_t;

    int n_vec = 0;
    int n_bad = 0;
    vec_t vt [23];

    function automatic vec_t mk(logic b0v, logic [13:0] b0pc, logic b0t,
                                logic b1v, logic [13:0] b1pc, logic b1t,
                                logic rdy, logic we, logic [3:0] idx, logic tk, logic err);
        vec_t v;
        v.b0v = b0v; v.b0pc = b0pc; v.b0t = b0t;
        v.b1v = b1v; v.b1pc = b1pc; v.b1t = b1t;
        v.rdy = rdy; v.we = we; v.idx = idx; v.tk = tk; v.err = err;
        return v;
    endfunction

    task automatic drive(input logic b0v, input logic [13:0] b0pc, input logic b0t,
                         input logic b1v, input logic [13:0] b1pc, input logic b1t);
        bus.br0_valid = b0v; bus.br0_pc = b0pc; bus.br0_taken = b0t;
        bus.br1_valid = b1v; bus.br1_pc = b1pc; bus.br1_taken = b1t;
    endtask

    task automatic idle();
        drive(1'b0, 14'h0, 1'b0, 1'b0, 14'h0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // idx is only meaningful when a write is expected; taken only for updates.
    task automatic expect_out(input string name, input logic rdy, input logic we,
                              input logic init, input logic [3:0] idx, input logic tk,
                              input logic done, input logic err);
        logic [10:0] a;
        logic [10:0] e;
        logic        mi;
        logic        mt;
        mi = we;
        mt = we & ~init;
        a = {bus.br_ready, bus.tbl_we, bus.tbl_init, (mi ? bus.tbl_idx : 4'h0),
             (mt ? bus.tbl_taken : 1'b0), bus.init_done, bus.err_drop};
        e = {rdy, we, init, (mi ? idx : 4'h0), (mt ? tk : 1'b0), done, err};
        n_vec++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s: got rdy=%b we=%b init=%b idx=%h tk=%b done=%b err=%b, required rdy=%b we=%b init=%b idx=%h tk=%b done=%b err=%b",
                     name, a[10], a[9], a[8], a[7:4], a[3], a[1], a[0],
                     e[10], e[9], e[8], e[7:4], e[3], e[1], e[0]);
        end
    endtask

    // Walk the init sweep from 'start' to the last index, then check the RUN entry cycle.
    task automatic sweep(input string name, input int start, input logic err);
        for (int i = start; i < 16; i++) begin
            #2;
            expect_out($sformatf("%s_idx%0d", name, i), 1'b0, 1'b1, 1'b1, 4'(i), 1'b0, 1'b0, err);
            tick();
        end
        #2;
        expect_out($sformatf("%s_done", name), 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1, err);
    endtask

    initial begin
        //           b0v  b0pc     b0t   b1v  b1pc     b1t   rdy  we   idx   tk   err
        vt[0]  = mk(1'b0, 14'h000, 1'b0, 1'b0, 14'h000, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0);
        vt[1]  = mk(1'b1, 14'h00A, 1'b1, 1'b0, 14'h000, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0);
        vt[2]  = mk(1'b0, 14'h000, 1'b0, 1'b0, 14'h000, 1'b0, 1'b1, 1'b1, 4'h2, 1'b1, 1'b0);
        vt[3]  = mk(1'b0, 14'h000, 1'b0, 1'b0, 14'h000, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0);
        vt[4]  = mk(1'b1, 14'h00A, 1'b0, 1'b1, 14'h01F, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0);
        vt[5]  = mk(1'b0, 14'h000, 1'b0, 1'b0, 14'h000, 1'b0, 1'b1, 1'b1, 4'h2, 1'b0, 1'b0);
        vt[6]  = mk(1'b0, 14'h000, 1'b0, 1'b0, 14'h000, 1'b0, 1'b1, 1'b1, 4'h7, 1'b1, 1'b0);
        vt[7]  = mk(1'b0, 14'h000, 1'b0, 1'b0, 14'h000, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0);
        vt[8]  = mk(1'b1, 14'h3FC, 1'b1, 1'b0, 14'h000, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0);
        vt[9]  = mk(1'b0, 14'h000, 1'b0, 1'b1, 14'h040, 1'b0, 1'b1, 1'b1, 4'hF, 1'b1, 1'b0);
        vt[10] = mk(1'b0, 14'h000, 1'b0, 1'b0, 14'h000, 1'b0, 1'b1, 1'b1, 4'h0, 1'b0, 1'b0);
        vt[11] = mk(1'b0, 14'h000, 1'b0, 1'b0, 14'h000, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0);
        vt[12] = mk(1'b1, 14'h00A, 1'b1, 1'b1, 14'h00A, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0);
        vt[13] = mk(1'b0, 14'h000, 1'b0, 1'b0, 14'h000, 1'b0, 1'b1, 1'b1, 4'h2, 1'b1, 1'b0);
        vt[14] = mk(1'b0, 14'h000, 1'b0, 1'b0, 14'h000, 1'b0, 1'b1, 1'b1, 4'h2, 1'b0, 1'b0);
        vt[15] = mk(1'b0, 14'h000, 1'b0, 1'b0, 14'h000, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0);
        vt[16] = mk(1'b1, 14'h004, 1'b1, 1'b1, 14'h008, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0);
        vt[17] = mk(1'b1, 14'h00C, 1'b1, 1'b1, 14'h010, 1'b1, 1'b1, 1'b1, 4'h1, 1'b1, 1'b0);
        vt[18] = mk(1'b1, 14'h014, 1'b0, 1'b1, 14'h018, 1'b0, 1'b0, 1'b1, 4'h2, 1'b0, 1'b0);
        vt[19] = mk(1'b0, 14'h000, 1'b0, 1'b0, 14'h000, 1'b0, 1'b1, 1'b1, 4'h3, 1'b1, 1'b1);
        vt[20] = mk(1'b0, 14'h000, 1'b0, 1'b0, 14'h000, 1'b0, 1'b1, 1'b1, 4'h4, 1'b1, 1'b1);
        vt[21] = mk(1'b0, 14'h000, 1'b0, 1'b0, 14'h000, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 1'b1);
        vt[22] = mk(1'b0, 14'h000, 1'b0, 1'b0, 14'h000, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 1'b1);

        rst = 1'b0;
        idle();
        #3;
        expect_out("reset_state", 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        sweep("sweep1", 0, 1'b0);

        for (int i = 0; i < 23; i++) begin
            drive(vt[i].b0v, vt[i].b0pc, vt[i].b0t, vt[i].b1v, vt[i].b1pc, vt[i].b1t);
            #2;
            expect_out($sformatf("vec%0d", i), vt[i].rdy, vt[i].we, 1'b0, vt[i].idx,
                       vt[i].tk, 1'b1, vt[i].err);
            tick();
        end

        // Queue three entries, then reset asynchronously mid-cycle.
        drive(1'b1, 14'h020, 1'b1, 1'b1, 14'h024, 1'b0);
        #2;
        expect_out("fill_a", 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b1);
        tick();
        drive(1'b1, 14'h028, 1'b1, 1'b1, 14'h02C, 1'b1);
        #2;
        expect_out("fill_b", 1'b1, 1'b1, 1'b0, 4'h8, 1'b1, 1'b1, 1'b1);
        tick();
        idle();
        #2;
        expect_out("fill_c", 1'b0, 1'b1, 1'b0, 4'h9, 1'b0, 1'b1, 1'b1);
        rst = 1'b0;
        #1;
        expect_out("rst_async", 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        rst = 1'b1;
        sweep("sweep2", 0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick();
            #2;
            expect_out($sformatf("no_stale%0d", i), 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
        end

        // An update offered during the sweep is dropped and flagged.
        tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        drive(1'b1, 14'h004, 1'b1, 1'b0, 14'h000, 1'b0);
        #2;
        expect_out("init_drop_c0", 1'b0, 1'b1, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0);
        tick();
        idle();
        sweep("sweep3", 1, 1'b1);
        for (int i = 0; i < 2; i++) begin
            tick();
            #2;
            expect_out($sformatf("init_drop_after%0d", i), 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
